inst_fetch_unit: RTL and testbench

//  Requester side of the instruction-ROM cs/a/spo/ack handshake. Owns the PC,

---
 rtl/cpu_defs_pkg.sv | 27 ++
 rtl/inst_fetch_unit_if_hold_reg.sv | 61 ++++++
 rtl/inst_fetch_unit.sv | 126 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the instruction fetch path.
//  - RESET_PC : default fetch address after reset
//  - INST_NOP : canonical no-op encoding (addi x0,x0,0)
//  - fetch_state_e : fetch FSM encoding (REQ waits for the ROM, HOLD presents
//    the fetched word to IF/ID)
//  - align_pc / next_pc : PC helpers used by the fetch unit
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

  // Word-align a byte address.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  // Sequential successor of a word-aligned PC; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if_hold_reg.sv
// Output holding register for the fetch unit: {valid, pc, inst} presented to
// the IF/ID register.
//  clk, rst_n : clock, asynchronous active-low reset (clears everything to 0)
//  load_i     : capture pc_i/inst_i and raise valid
//  accept_i   : consumer took the word; drop valid, keep the data
//  flush_i    : discard the held word (highest priority)
//  pc_i/inst_i: word being captured
//  valid_o/pc_o/inst_o : registered outputs
module if_hold_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        accept_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Next-state selection: flush beats load beats accept.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end else if (accept_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      inst_q  <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: requester side of the inst_rom cs/a/spo/ack
// handshake. Owns the PC, waits for ack (no fixed latency), and presents
// {pc, inst} to IF/ID with a valid/ready handshake. Redirects override all
// other events in the cycle they arrive.
//  clk, rst_n            : clock, asynchronous active-low reset
//  rom_cs, rom_a         : ROM request and word address (pc[AW+1:2])
//  rom_spo, rom_ack      : ROM data and its valid strobe
//  if_valid/if_ready     : IF/ID handshake
//  if_inst, if_pc        : fetched word and its byte PC
//  redirect, redirect_pc : one-cycle redirect pulse and target
//  fetch_err             : sticky ROM timeout flag
module inst_fetch_unit #(
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter int          TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          rom_cs,
  output logic [AW-1:0] rom_a,
  input  logic [31:0]   rom_spo,
  input  logic          rom_ack,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [31:0]   if_inst,
  output logic [31:0]   if_pc,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          fetch_err
);
  import cpu_defs::*;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          cs_q;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
  logic          hold_load_s, hold_accept_s, hold_flush_s;

  // Fetch FSM, PC and timeout counter next-state logic.
  // The PC already points at the next word while HOLD presents the current
  // one, so the ROM starts the following access as soon as HOLD is entered.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    to_cnt_d      = to_cnt_q;
    hold_load_s   = 1'b0;
    hold_accept_s = 1'b0;
    hold_flush_s  = 1'b0;
    if (redirect) begin
      pc_d         = align_pc(redirect_pc);
      state_d      = ST_REQ;
      hold_flush_s = 1'b1;
      to_cnt_d     = {CW{1'b0}};
    end else begin
      case (state_q)
        ST_REQ: begin
          if (cs_q && rom_ack) begin
            hold_load_s = 1'b1;
            pc_d        = next_pc(pc_q);
            state_d     = ST_HOLD;
            to_cnt_d    = {CW{1'b0}};
          end else if (cs_q && (to_cnt_q != TO_LIMIT)) begin
            to_cnt_d = to_cnt_q + CW'(1'b1);
          end else begin
            to_cnt_d = to_cnt_q;
          end
        end
        ST_HOLD: begin
          if (if_ready) begin
            hold_accept_s = 1'b1;
            state_d       = ST_REQ;
            to_cnt_d      = {CW{1'b0}};
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d  = ST_REQ;
          to_cnt_d = {CW{1'b0}};
        end
      endcase
    end
    err_d = err_q | (to_cnt_d == TO_LIMIT);
  end

  // Fetch state registers; rom_cs rises on the first edge after reset release
  // and drops asynchronously with rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      cs_q     <= 1'b0;
      to_cnt_q <= {CW{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cs_q     <= 1'b1;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  if_hold_reg u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (hold_load_s),
    .accept_i (hold_accept_s),
    .flush_i  (hold_flush_s),
    .pc_i     (pc_q),
    .inst_i   (rom_spo),
    .valid_o  (if_valid),
    .pc_o     (if_pc),
    .inst_o   (if_inst)
  );

  // Upper PC bits are not decoded: the ROM address aliases modulo 2^AW words.
  assign rom_a     = pc_q[AW+1:2];
  assign rom_cs    = cs_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit paired with a behavioural inst_rom (DELAY=3,
// ROM[i]=A000_0000+i). A scoreboard holds the expected instruction stream
// (sequential PCs from the last reset/redirect target); a monitor pops it on
// every IF/ID handshake.
module tb_inst_fetch_unit;
  localparam int AW      = 10;
  localparam int DELAY   = 3;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rom_cs;
  logic [AW-1:0] rom_a;
  logic [31:0]   rom_spo;
  logic          rom_ack;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_inst;
  logic [31:0]   if_pc;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          fetch_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cnt = 0;
  bit tput_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_fetch_unit #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rom_cs(rom_cs), .rom_a(rom_a),
    .rom_spo(rom_spo), .rom_ack(rom_ack), .if_valid(if_valid),
    .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  // Behavioural ROM: data valid once the address has been stable for DELAY
  // edges; restarts on any address change or while deselected.
  logic [AW-1:0] rom_last_a = '0;
  int            rom_cnt = 0;
  logic          rom_mute = 1'b0;
  always @(posedge clk) begin
    if (!rom_cs || rom_a != rom_last_a) begin
      rom_last_a <= rom_a;
      rom_cnt    <= 0;
    end else if (rom_cnt < DELAY) begin
      rom_cnt <= rom_cnt + 1;
    end
  end
  assign rom_ack = rom_cs && !rom_mute && (rom_a == rom_last_a) && (rom_cnt >= DELAY - 1);
  assign rom_spo = rom_ack ? (32'hA000_0000 + 32'(rom_a)) : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb_q[$];

  // Expected stream after a restart: consecutive words, ROM aliased mod 1024.
  function automatic void sb_restart(input logic [31:0] start);
    logic [31:0] p;
    exp_t e;
    p = start & 32'hFFFF_FFFC;
    sb_q.delete();
    for (int i = 0; i < 400; i++) begin
      e.pc   = p;
      e.inst = 32'hA000_0000 + ((p >> 2) % 32'd1024);
      sb_q.push_back(e);
      p = p + 32'd4;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    sb_restart(t);
    step();
    redirect = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Monitor: handshake scoreboard, stall stability, and steady-state spacing.
  initial begin : monitor
    bit          prev_hold;
    bit          prev_tput;
    int          last_acc;
    logic [31:0] prev_pc, prev_inst;
    logic [AW-1:0] prev_a;
    exp_t        e;
    prev_hold = 1'b0;
    prev_tput = 1'b0;
    last_acc  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        prev_tput = 1'b0;
      end else begin
        if (prev_hold && !redirect) begin
          chk("stall_valid", 32'(if_valid), 32'd1);
          chk("stall_pc", if_pc, prev_pc);
          chk("stall_inst", if_inst, prev_inst);
          chk("stall_rom_a", 32'(rom_a), 32'(prev_a));
        end
        if (if_valid && if_ready && !redirect) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            chk("sb_pc", if_pc, e.pc);
            chk("sb_inst", if_inst, e.inst);
          end
          acc_cnt++;
          if (tput_en && prev_tput) chk("throughput_gap", 32'(cyc - last_acc), 32'd4);
          prev_tput = tput_en;
          last_acc  = cyc;
        end
        prev_hold = if_valid && !if_ready && !redirect;
        prev_pc   = if_pc;
        prev_inst = if_inst;
        prev_a    = rom_a;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int base, cs_cyc, err_cyc;
    bit vseen;
    rst_n = 1'b0; if_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    sb_restart(32'h0);
    repeat (3) step();
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_rom_a", 32'(rom_a), 32'd0);
    rst_n = 1'b1;
    step();
    chk("cs_after_release", 32'(rom_cs), 32'd1);

    // Stall while HOLD presents pc=8.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (if_valid && if_pc == 32'h8) begin ok = 1'b1; if_ready = 1'b0; break; end
      step();
    end
    chk("find_pc8", 32'(ok), 32'd1);
    repeat (10) step();
    chk("stall_end_inst", if_inst, 32'hA000_0002);
    chk("stall_end_pc", if_pc, 32'h8);
    chk("stall_end_rom_a", 32'(rom_a), 32'd3);
    if_ready = 1'b1;

    // Steady-state throughput with if_ready=1.
    base = acc_cnt;
    for (int i = 0; i < 60 && acc_cnt < base + 3; i++) step();
    chk("warmup_accepts", 32'(acc_cnt >= base + 3), 32'd1);
    tput_en = 1'b1;
    repeat (48) step();
    tput_en = 1'b0;

    // Redirect one cycle into the access for 0x40.
    do_redirect(32'h40);
    step();
    do_redirect(32'h103);
    wait_valid(50, ok);
    chk("redir_wait", 32'(ok), 32'd1);
    chk("redir_pc", if_pc, 32'h100);
    chk("redir_inst", if_inst, 32'hA000_0040);

    // Redirect coinciding with the ack.
    step();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rom_ack && rom_cs && !if_valid) begin ok = 1'b1; break; end
      step();
    end
    chk("ack_seen", 32'(ok), 32'd1);
    do_redirect(32'h200);
    wait_valid(50, ok);
    chk("ack_redir_pc", if_pc, 32'h200);

    // Randomized ready stalls and redirects.
    base = acc_cnt;
    for (int i = 0; i < 1500; i++) begin
      if_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 24) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
        sb_restart(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
      step();
    end
    redirect = 1'b0; if_ready = 1'b1;
    repeat (10) step();
    chk("random_progress", 32'(acc_cnt - base > 50), 32'd1);
    chk("no_fetch_err", 32'(fetch_err), 32'd0);

    // Reset asserted while the access after pc=0x20 is in flight.
    do_redirect(32'h20);
    if_ready = 1'b0;
    wait_valid(50, ok);
    chk("hold_0x20", if_pc, 32'h20);
    rst_n = 1'b0;
    sb_restart(32'h0);
    #1;
    chk("arst_rom_cs", 32'(rom_cs), 32'd0);
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    step(); step();
    if_ready = 1'b1;
    rst_n = 1'b1;
    step();
    wait_valid(50, ok);
    chk("restart_pc", if_pc, 32'h0);

    // ROM that never acks.
    rst_n = 1'b0; rom_mute = 1'b1;
    sb_restart(32'h0);
    step(); step();
    rst_n = 1'b1;
    cs_cyc = -1; err_cyc = -1; vseen = 1'b0;
    for (int n = 0; n < 150; n++) begin
      step();
      if (rom_cs && cs_cyc < 0) cs_cyc = n;
      if (fetch_err && err_cyc < 0) err_cyc = n;
      if (if_valid) vseen = 1'b1;
    end
    chk("timeout_seen", 32'(err_cyc >= 0), 32'd1);
    chk("timeout_cycles", 32'(err_cyc - cs_cyc), 32'd64);
    chk("timeout_no_valid", 32'(vseen), 32'd0);
    rom_mute = 1'b0;
    wait_valid(50, ok);
    chk("late_ack_pc", if_pc, 32'h0);
    chk("err_sticky", 32'(fetch_err), 32'd1);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
